// File: rtl/ex_stage.sv
// ex_stage: execute stage of the integer pipeline.
//   LOGIC / SHIFT / ARITH classes resolve combinationally in one cycle.
//   DIV class uses an iterative restoring divider (one quotient bit per
//   cycle) behind an IDLE/BUSY/DONE FSM that stalls the ID/EX register.
// Optional feature: define EX_SIGNED_DIV_EN to add signed DIV/REM (0x32/0x33).
// Without it those opcodes behave like any unknown opcode.

module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [3:0]  alusel_i,
  input  logic [63:0] oprand1_i,
  input  logic [63:0] oprand2_i,
  input  logic [4:0]  reg_write_addr_i,
  input  logic        reg_write_enable_i,
  input  logic        mem_valid_i,
  input  logic        mem_rw_i,
  output logic [63:0] reg_write_data_o,
  output logic [4:0]  reg_write_addr_o,
  output logic        reg_write_enable_o,
  output logic        mem_valid_o,
  output logic        mem_rw_o,
  output logic        stall_req_o
);

  localparam logic [3:0] SEL_LOGIC = 4'd1;
  localparam logic [3:0] SEL_SHIFT = 4'd2;
  localparam logic [3:0] SEL_ARITH = 4'd3;
  localparam logic [3:0] SEL_DIV   = 4'd4;

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_SLL  = 8'h10;
  localparam logic [7:0] OP_SRL  = 8'h11;
  localparam logic [7:0] OP_SRA  = 8'h12;
  localparam logic [7:0] OP_ADD  = 8'h20;
  localparam logic [7:0] OP_SUB  = 8'h21;
  localparam logic [7:0] OP_SLT  = 8'h22;
  localparam logic [7:0] OP_SLTU = 8'h23;
  localparam logic [7:0] OP_DIVU = 8'h30;
  localparam logic [7:0] OP_REMU = 8'h31;
`ifdef EX_SIGNED_DIV_EN
  localparam logic [7:0] OP_DIV  = 8'h32;
  localparam logic [7:0] OP_REM  = 8'h33;
  localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [63:0] alu_res;
  logic        is_div;
  logic        div_zero;
  logic        div_ovf;
  logic [63:0] a_mag;
  logic [63:0] b_mag;

  // Divider datapath: quo_q starts as the dividend and shifts quotient bits in.
  logic [63:0] quo_q;
  logic [63:0] rem_q;
  logic [63:0] dvs_q;
  logic [5:0]  cnt_q;
  logic        rem_sel_q;
  logic [4:0]  addr_q;
  logic        we_q;
  logic [64:0] rem_sh;
  logic [64:0] rem_diff;
  logic [63:0] div_res;

`ifdef EX_SIGNED_DIV_EN
  logic op_signed;
  logic a_neg;
  logic b_neg;
  logic q_neg_q;
  logic r_neg_q;
`endif

  // Single-cycle ALU result; unknown class/opcode yields zero
  always_comb begin
    alu_res = '0;
    case (alusel_i)
      SEL_LOGIC: begin
        case (aluop_i)
          OP_AND:  alu_res = oprand1_i & oprand2_i;
          OP_OR:   alu_res = oprand1_i | oprand2_i;
          OP_XOR:  alu_res = oprand1_i ^ oprand2_i;
          default: alu_res = '0;
        endcase
      end
      SEL_SHIFT: begin
        case (aluop_i)
          OP_SLL:  alu_res = oprand1_i << oprand2_i[5:0];
          OP_SRL:  alu_res = oprand1_i >> oprand2_i[5:0];
          OP_SRA:  alu_res = $signed(oprand1_i) >>> oprand2_i[5:0];
          default: alu_res = '0;
        endcase
      end
      SEL_ARITH: begin
        case (aluop_i)
          OP_ADD:  alu_res = oprand1_i + oprand2_i;
          OP_SUB:  alu_res = oprand1_i - oprand2_i;
          OP_SLT:  alu_res = {63'd0, $signed(oprand1_i) < $signed(oprand2_i)};
          OP_SLTU: alu_res = {63'd0, oprand1_i < oprand2_i};
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  // Only recognised division opcodes start the divider
  always_comb begin
    is_div = 1'b0;
    if (alusel_i == SEL_DIV) begin
      case (aluop_i)
        OP_DIVU, OP_REMU: is_div = 1'b1;
`ifdef EX_SIGNED_DIV_EN
        OP_DIV, OP_REM:   is_div = 1'b1;
`endif
        default:          is_div = 1'b0;
      endcase
    end
  end

  // Operand conditioning: magnitudes for signed ops, special-case detection
  always_comb begin
    div_zero = (oprand2_i == '0);
`ifdef EX_SIGNED_DIV_EN
    op_signed = aluop_i[1];
    a_neg     = op_signed & oprand1_i[63];
    b_neg     = op_signed & oprand2_i[63];
    a_mag     = a_neg ? (~oprand1_i + 64'd1) : oprand1_i;
    b_mag     = b_neg ? (~oprand2_i + 64'd1) : oprand2_i;
    div_ovf   = op_signed && (oprand1_i == INT_MIN) && (oprand2_i == '1);
`else
    a_mag     = oprand1_i;
    b_mag     = oprand2_i;
    div_ovf   = 1'b0;
`endif
  end

  // One restoring step: shift next dividend bit into the partial remainder
  always_comb begin
    rem_sh   = {rem_q, quo_q[63]};
    rem_diff = rem_sh - {1'b0, dvs_q};
  end

  // Final result selection with sign fix-up
  always_comb begin
    div_res = rem_sel_q ? rem_q : quo_q;
`ifdef EX_SIGNED_DIV_EN
    if (rem_sel_q ? r_neg_q : q_neg_q)
      div_res = ~div_res + 64'd1;
`endif
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state; special cases skip the iteration entirely
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (is_div) state_nxt = (div_zero || div_ovf) ? DONE : BUSY;
      BUSY:    if (cnt_q == 6'd63) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Divider datapath: latch on entry, iterate while busy, hold in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
`ifdef EX_SIGNED_DIV_EN
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (is_div) begin
            rem_sel_q <= aluop_i[0];
            addr_q    <= reg_write_addr_i;
            we_q      <= reg_write_enable_i;
            cnt_q     <= '0;
            dvs_q     <= b_mag;
            // Special results are preloaded so DONE reads them unmodified
            if (div_zero) begin
              quo_q <= '1;
              rem_q <= oprand1_i;
            end else if (div_ovf) begin
              quo_q <= oprand1_i;
              rem_q <= '0;
            end else begin
              quo_q <= a_mag;
              rem_q <= '0;
            end
`ifdef EX_SIGNED_DIV_EN
            q_neg_q <= !div_zero && !div_ovf && (a_neg ^ b_neg);
            r_neg_q <= !div_zero && !div_ovf && a_neg;
`endif
          end
        end
        BUSY: begin
          if (!rem_diff[64]) begin
            rem_q <= rem_diff[63:0];
            quo_q <= {quo_q[62:0], 1'b1};
          end else begin
            rem_q <= rem_sh[63:0];
            quo_q <= {quo_q[62:0], 1'b0};
          end
          if (cnt_q != 6'd63) cnt_q <= cnt_q + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Output mux: pass-through ALU, stall while dividing, latched result in DONE
  always_comb begin
    reg_write_data_o   = '0;
    reg_write_addr_o   = '0;
    reg_write_enable_o = 1'b0;
    mem_valid_o        = 1'b0;
    mem_rw_o           = 1'b0;
    stall_req_o        = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          reg_write_addr_o = reg_write_addr_i;
          if (is_div) begin
            stall_req_o = 1'b1;
          end else begin
            reg_write_data_o   = alu_res;
            reg_write_enable_o = reg_write_enable_i;
            mem_valid_o        = mem_valid_i;
            mem_rw_o           = mem_rw_i;
          end
        end
        BUSY: begin
          stall_req_o      = 1'b1;
          reg_write_addr_o = addr_q;
        end
        DONE: begin
          reg_write_data_o   = div_res;
          reg_write_addr_o   = addr_q;
          reg_write_enable_o = we_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized self-checking bench for ex_stage against a
// behavioural model built from plain SV arithmetic.

module tb_ex_stage;

`ifdef EX_SIGNED_DIV_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [3:0]  alusel_i;
  logic [63:0] oprand1_i, oprand2_i;
  logic [4:0]  reg_write_addr_i;
  logic        reg_write_enable_i, mem_valid_i, mem_rw_i;
  logic [63:0] reg_write_data_o;
  logic [4:0]  reg_write_addr_o;
  logic        reg_write_enable_o, mem_valid_o, mem_rw_o, stall_req_o;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst),
    .aluop_i(aluop_i), .alusel_i(alusel_i),
    .oprand1_i(oprand1_i), .oprand2_i(oprand2_i),
    .reg_write_addr_i(reg_write_addr_i), .reg_write_enable_i(reg_write_enable_i),
    .mem_valid_i(mem_valid_i), .mem_rw_i(mem_rw_i),
    .reg_write_data_o(reg_write_data_o), .reg_write_addr_o(reg_write_addr_o),
    .reg_write_enable_o(reg_write_enable_o), .mem_valid_o(mem_valid_o),
    .mem_rw_o(mem_rw_o), .stall_req_o(stall_req_o)
  );

  function automatic logic [63:0] model_alu(logic [3:0] sel, logic [7:0] op,
                                            logic [63:0] a, logic [63:0] b);
    case (sel)
      4'd1: case (op)
        8'h01: return a & b;
        8'h02: return a | b;
        8'h03: return a ^ b;
        default: return 64'd0;
      endcase
      4'd2: case (op)
        8'h10: return a << b[5:0];
        8'h11: return a >> b[5:0];
        8'h12: return $signed(a) >>> b[5:0];
        default: return 64'd0;
      endcase
      4'd3: case (op)
        8'h20: return a + b;
        8'h21: return a - b;
        8'h22: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
        8'h23: return (a < b) ? 64'd1 : 64'd0;
        default: return 64'd0;
      endcase
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit model_is_div(logic [7:0] op);
    return (op == 8'h30) || (op == 8'h31) || (SIGNED_EN && (op == 8'h32 || op == 8'h33));
  endfunction

  // Expected data seen once the stall drops (0 for non-division opcodes)
  function automatic logic [63:0] model_div(logic [7:0] op, logic [63:0] a, logic [63:0] b);
    logic signed [63:0] sa, sb;
    sa = a; sb = b;
    if (!model_is_div(op)) return 64'd0;
    if (b == 64'd0) return op[0] ? a : '1;
    case (op)
      8'h30: return a / b;
      8'h31: return a % b;
      default: begin
        if (a == MINV && b == '1) return op[0] ? 64'd0 : a;
        if (op == 8'h32) return sa / sb;
        return sa % sb;
      end
    endcase
  endfunction

  function automatic int model_stall(logic [7:0] op, logic [63:0] a, logic [63:0] b);
    if (!model_is_div(op)) return 0;
    if (b == 64'd0) return 1;
    if (op[1] && a == MINV && b == '1) return 1;
    return 65;
  endfunction

  task automatic drive(input logic [3:0] sel, input logic [7:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] ad, input logic we,
                       input logic mv, input logic rw);
    alusel_i = sel; aluop_i = op; oprand1_i = a; oprand2_i = b;
    reg_write_addr_i = ad; reg_write_enable_i = we; mem_valid_i = mv; mem_rw_i = rw;
  endtask

  // Launch a DIV-class op, count stall cycles, capture the first non-stall cycle
  task automatic run_div(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] ad, input logic we, output int stalls,
                         output logic [63:0] d, output logic [4:0] ado, output logic e,
                         output int viol);
    @(negedge clk);
    drive(4'd4, op, a, b, ad, we, 1'b1, 1'b1);
    #1;
    stalls = 0; viol = 0;
    while (stall_req_o === 1'b1 && stalls < 200) begin
      if (reg_write_enable_o !== 1'b0 || mem_valid_o !== 1'b0) viol++;
      stalls++;
      @(negedge clk); #1;
    end
    d = reg_write_data_o; ado = reg_write_addr_o; e = reg_write_enable_o;
    drive(4'd0, 8'h00, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic div_case(input string nm, input logic [7:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] ad, input logic we);
    int st, vi; logic [63:0] d; logic [4:0] ado; logic e;
    int exp_st; logic [63:0] exp_d;
    exp_st = model_stall(op, a, b);
    exp_d  = model_div(op, a, b);
    run_div(op, a, b, ad, we, st, d, ado, e, vi);
    checks++;
    if (st !== exp_st || d !== exp_d || ado !== ad || e !== we || vi != 0)
      $display("FAIL %s op=%h a=%h b=%h: got stall=%0d data=%h addr=%0d we=%b viol=%0d, want stall=%0d data=%h addr=%0d we=%b viol=0",
               nm, op, a, b, st, d, ado, e, vi, exp_st, exp_d, ad, we);
    else passes++;
  endtask

  task automatic test_reset();
    logic [74:0] obs;
    rst = 1'b1;
    drive(4'd3, 8'h20, 64'h1234, 64'h1, 5'd7, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    obs = {reg_write_data_o, reg_write_addr_o, reg_write_enable_o, mem_valid_o, mem_rw_o, stall_req_o};
    checks++;
    if (obs !== '0) $display("FAIL reset_alu: got %h want 0", obs); else passes++;
    drive(4'd4, 8'h30, 64'd100, 64'd7, 5'd5, 1'b1, 1'b1, 1'b1);
    @(negedge clk); #1;
    obs = {reg_write_data_o, reg_write_addr_o, reg_write_enable_o, mem_valid_o, mem_rw_o, stall_req_o};
    checks++;
    if (obs !== '0) $display("FAIL reset_div: got %h want 0", obs); else passes++;
    drive(4'd0, 8'h00, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    @(negedge clk);
    drive(4'd3, 8'h20, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd3, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (reg_write_data_o !== MINV || stall_req_o !== 1'b0)
      $display("FAIL add_overflow: got data=%h stall=%b want data=%h stall=0", reg_write_data_o, stall_req_o, MINV);
    else passes++;
    @(negedge clk);
    drive(4'd2, 8'h12, MINV, 64'd63, 5'd3, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (reg_write_data_o !== 64'hFFFF_FFFF_FFFF_FFFF)
      $display("FAIL sra63: got %h want ffffffffffffffff", reg_write_data_o);
    else passes++;
  endtask

  task automatic test_alu_random();
    logic [3:0] sel; logic [7:0] op; logic [63:0] a, b; logic [4:0] ad;
    logic we, mv, rw; logic [74:0] obs, exp;
    for (int i = 0; i < 80; i++) begin
      sel = 4'($urandom_range(0, 15));
      case (sel)
        4'd1: op = 8'($urandom_range(1, 3));
        4'd2: op = 8'($urandom_range(8'h10, 8'h12));
        4'd3: op = 8'($urandom_range(8'h20, 8'h23));
        default: op = 8'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) op = 8'($urandom);
      if (sel == 4'd4) op = 8'($urandom_range(8'h34, 8'hFF));
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 70));
      ad = 5'($urandom); we = 1'($urandom); mv = 1'($urandom); rw = 1'($urandom);
      @(negedge clk);
      drive(sel, op, a, b, ad, we, mv, rw);
      #1;
      obs = {reg_write_data_o, reg_write_addr_o, reg_write_enable_o, mem_valid_o, mem_rw_o, stall_req_o};
      exp = {model_alu(sel, op, a, b), ad, we, mv, rw, 1'b0};
      checks++;
      if (obs !== exp)
        $display("FAIL alu_rand sel=%0d op=%h a=%h b=%h: got %h want %h", sel, op, a, b, obs, exp);
      else passes++;
    end
    @(negedge clk);
    drive(4'd0, 8'h00, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_div_unsigned();
    div_case("divu_100_7", 8'h30, 64'd100, 64'd7, 5'd5, 1'b1);
    div_case("remu_100_7", 8'h31, 64'd100, 64'd7, 5'd5, 1'b1);
    div_case("divu_by0",   8'h30, 64'd5, 64'd0, 5'd9, 1'b1);
    div_case("remu_by0",   8'h31, 64'd5, 64'd0, 5'd9, 1'b0);
    div_case("divu_max",   8'h30, '1, 64'd1, 5'd31, 1'b1);
    for (int i = 0; i < 4; i++)
      div_case("divu_rand", 8'(8'h30 + $urandom_range(0, 1)), {$urandom, $urandom},
               ($urandom_range(0, 1) == 0) ? 64'($urandom) : {$urandom, $urandom},
               5'($urandom), 1'($urandom));
  endtask

  task automatic test_div_signed();
    div_case("div_m7_2", 8'h32, -64'sd7, 64'd2, 5'd4, 1'b1);
    div_case("rem_m7_2", 8'h33, -64'sd7, 64'd2, 5'd4, 1'b1);
    div_case("div_ovf",  8'h32, MINV, '1, 5'd6, 1'b1);
    div_case("rem_ovf",  8'h33, MINV, '1, 5'd6, 1'b1);
    div_case("rem_by0",  8'h33, -64'sd9, 64'd0, 5'd2, 1'b1);
    for (int i = 0; i < 3; i++)
      div_case("sdiv_rand", 8'(8'h32 + $urandom_range(0, 1)), {$urandom, $urandom},
               {{32{$urandom_range(0, 1) == 1}}, 32'($urandom)}, 5'($urandom), 1'b1);
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    drive(4'd4, 8'h30, 64'd100, 64'd7, 5'd5, 1'b1, 1'b1, 1'b0);
    repeat (31) @(negedge clk);
    #1;
    checks++;
    if (stall_req_o !== 1'b1) $display("FAIL busy_before_rst: got stall=%b want 1", stall_req_o);
    else passes++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(4'd0, 8'h00, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (stall_req_o !== 1'b0 || reg_write_enable_o !== 1'b0 || reg_write_data_o !== 64'd0)
        $display("FAIL after_rst[%0d]: got stall=%b we=%b data=%h want 0 0 0",
                 i, stall_req_o, reg_write_enable_o, reg_write_data_o);
      else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    drive(4'd4, 8'h30, 64'd1000, 64'd10, 5'd12, 1'b1, 1'b0, 1'b0);
    #1;
    n = 0;
    while (stall_req_o === 1'b1 && n < 200) begin n++; @(negedge clk); #1; end
    // DONE cycle: new inputs must not disturb the latched result
    drive(4'd3, 8'h20, 64'd1, 64'd2, 5'd9, 1'b1, 1'b1, 1'b1);
    #1;
    checks++;
    if (n != 65 || reg_write_data_o !== 64'd100 || reg_write_addr_o !== 5'd12 ||
        reg_write_enable_o !== 1'b1 || mem_valid_o !== 1'b0)
      $display("FAIL done_holds: got stall=%0d data=%h addr=%0d we=%b mv=%b want 65 100 12 1 0",
               n, reg_write_data_o, reg_write_addr_o, reg_write_enable_o, mem_valid_o);
    else passes++;
    @(negedge clk); #1;
    checks++;
    if (reg_write_data_o !== 64'd3 || reg_write_addr_o !== 5'd9 || stall_req_o !== 1'b0 ||
        mem_valid_o !== 1'b1)
      $display("FAIL next_alu: got data=%h addr=%0d stall=%b mv=%b want 3 9 0 1",
               reg_write_data_o, reg_write_addr_o, stall_req_o, mem_valid_o);
    else passes++;
    drive(4'd0, 8'h00, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    div_case("b2b_remu", 8'h31, 64'd1003, 64'd10, 5'd1, 1'b1);
  endtask

  initial begin
    drive(4'd0, 8'h00, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    test_reset();
    test_directed();
    test_alu_random();
    test_div_unsigned();
    test_div_signed();
    test_reset_mid_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
